trigger_sequencer: RTL and testbench

- Multi-stage trigger controller in the clk_usb domain that sequences up to pNUM_SRC trigger sources (edge_trigger instances and similar).
- Enables one source at a time through src_active[i], waits for that source's event, then advances to the next stage.
- Issues one trigger_out pulse when the final stage fires.
- Enforces an optional inter-stage timeout window; configured and monitored through the standard USB register interface.

---
 rtl/trigger_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer: arms sources one at a time, advances on each source event,
// pulses trigger_out when the last stage fires, with an optional inter-stage timeout window.
module trigger_sequencer #(
  parameter int          pNUM_SRC      = 4,
  parameter int          pBYTECNT_SIZE = 7,
  parameter logic [7:0]  pADDR_CFG     = 8'h50,
  parameter logic [7:0]  pADDR_WINDOW  = 8'h51,
  parameter logic [7:0]  pADDR_STATUS  = 8'h52
) (
  input  logic                     clk_usb,
  input  logic                     reset,
  input  logic [7:0]               reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               reg_datai,
  output logic [7:0]               reg_datao,
  input  logic                     reg_read,
  input  logic                     reg_write,
  input  logic                     arm,
  input  logic [pNUM_SRC-1:0]      src_toggle,
  output logic [pNUM_SRC-1:0]      src_active,
  output logic                     trigger_out,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STAGE  = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAILED = 2'd3
  } state_t;

  localparam logic [pBYTECNT_SIZE-1:0] BC0 = '0;
  localparam logic [pBYTECNT_SIZE-1:0] BC1 = pBYTECNT_SIZE'(1);

  logic [pNUM_SRC-1:0] event_vec;

  // Toggle-to-pulse detection: two synchronizer flops plus one history flop per source.
  generate
    for (genvar gi = 0; gi < pNUM_SRC; gi++) begin : g_sync
      logic s1_reg, s2_reg, s3_reg;
      always_ff @(posedge clk_usb) begin
        if (reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
          s3_reg <= 1'b0;
        end else begin
          s1_reg <= src_toggle[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end
      assign event_vec[gi] = s2_reg ^ s3_reg;
    end
  endgenerate

  logic [7:0]  cfg_stages_reg;
  logic        cfg_enable_reg;
  logic        cfg_restart_reg;
  logic [15:0] window_reg;

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      cfg_stages_reg  <= 8'd0;
      cfg_enable_reg  <= 1'b0;
      cfg_restart_reg <= 1'b0;
      window_reg      <= 16'd0;
    end else if (reg_write) begin
      if (reg_address == pADDR_CFG) begin
        if (reg_bytecnt == BC0) begin
          cfg_stages_reg <= reg_datai;
        end else if (reg_bytecnt == BC1) begin
          cfg_enable_reg  <= reg_datai[0];
          cfg_restart_reg <= reg_datai[1];
        end
      end
      if (reg_address == pADDR_WINDOW) begin
        if (reg_bytecnt == BC0) begin
          window_reg[7:0] <= reg_datai;
        end else if (reg_bytecnt == BC1) begin
          window_reg[15:8] <= reg_datai;
        end
      end
    end
  end

  state_t              state_reg, state_next;
  logic [3:0]          stage_reg, stage_next;
  logic [15:0]         win_cnt_reg, win_cnt_next;
  logic [pNUM_SRC-1:0] active_reg, active_next;
  logic                trig_reg, trig_next;
  logic [3:0]          shadow_num_reg, shadow_num_next;
  logic [15:0]         shadow_win_reg, shadow_win_next;
  logic [7:0]          tcnt_reg, tcnt_next;
  logic                arm_reg;
  logic [3:0]          num_clamped;
  logic                evt_sel;
  logic                status_wr;

  always_comb begin
    if (cfg_stages_reg == 8'd0) begin
      num_clamped = 4'd1;
    end else if (cfg_stages_reg > 8'(pNUM_SRC)) begin
      num_clamped = 4'(pNUM_SRC);
    end else begin
      num_clamped = cfg_stages_reg[3:0];
    end
  end

  always_comb begin
    evt_sel = 1'b0;
    for (int i = 0; i < pNUM_SRC; i++) begin
      if (stage_reg == 4'(i)) evt_sel = event_vec[i];
    end
  end

  assign status_wr = reg_write && (reg_address == pADDR_STATUS);

  always_comb begin
    state_next      = state_reg;
    stage_next      = stage_reg;
    win_cnt_next    = win_cnt_reg;
    active_next     = active_reg;
    trig_next       = 1'b0;
    shadow_num_next = shadow_num_reg;
    shadow_win_next = shadow_win_reg;
    tcnt_next       = tcnt_reg;
    case (state_reg)
      ST_IDLE: begin
        active_next = '0;
        if (arm && !arm_reg && cfg_enable_reg) begin
          state_next      = ST_STAGE;
          stage_next      = 4'd0;
          win_cnt_next    = 16'd0;
          active_next     = pNUM_SRC'(1);
          shadow_num_next = num_clamped;
          shadow_win_next = window_reg;
        end
      end
      ST_STAGE: begin
        if (!arm || !cfg_enable_reg) begin
          state_next  = ST_IDLE;
          active_next = '0;
        end else if (evt_sel) begin
          // An event always beats a coincident timeout.
          if (stage_reg == shadow_num_reg - 4'd1) begin
            state_next  = ST_DONE;
            active_next = '0;
            trig_next   = 1'b1;
          end else begin
            stage_next   = stage_reg + 4'd1;
            active_next  = active_reg << 1;
            win_cnt_next = 16'd0;
          end
        end else if (stage_reg != 4'd0 && shadow_win_reg != 16'd0) begin
          if (win_cnt_reg == shadow_win_reg - 16'd1) begin
            if (tcnt_reg != 8'hFF) tcnt_next = tcnt_reg + 8'd1;
            if (cfg_restart_reg) begin
              stage_next   = 4'd0;
              active_next  = pNUM_SRC'(1);
              win_cnt_next = 16'd0;
            end else begin
              state_next  = ST_FAILED;
              active_next = '0;
            end
          end else begin
            win_cnt_next = win_cnt_reg + 16'd1;
          end
        end
      end
      default: begin
        active_next = '0;
        if (!arm) state_next = ST_IDLE;
      end
    endcase
    if (status_wr) tcnt_next = 8'd0;
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      stage_reg      <= 4'd0;
      win_cnt_reg    <= 16'd0;
      active_reg     <= '0;
      trig_reg       <= 1'b0;
      shadow_num_reg <= 4'd0;
      shadow_win_reg <= 16'd0;
      tcnt_reg       <= 8'd0;
      arm_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stage_reg      <= stage_next;
      win_cnt_reg    <= win_cnt_next;
      active_reg     <= active_next;
      trig_reg       <= trig_next;
      shadow_num_reg <= shadow_num_next;
      shadow_win_reg <= shadow_win_next;
      tcnt_reg       <= tcnt_next;
      arm_reg        <= arm;
    end
  end

  always_comb begin
    reg_datao = 8'h00;
    if (reg_read) begin
      case (reg_address)
        pADDR_CFG: begin
          if (reg_bytecnt == BC0)      reg_datao = cfg_stages_reg;
          else if (reg_bytecnt == BC1) reg_datao = {6'd0, cfg_restart_reg, cfg_enable_reg};
        end
        pADDR_WINDOW: begin
          if (reg_bytecnt == BC0)      reg_datao = window_reg[7:0];
          else if (reg_bytecnt == BC1) reg_datao = window_reg[15:8];
        end
        pADDR_STATUS: begin
          if (reg_bytecnt == BC0)      reg_datao = {2'b00, state_reg, stage_reg};
          else if (reg_bytecnt == BC1) reg_datao = tcnt_reg;
        end
        default: reg_datao = 8'h00;
      endcase
    end
  end

  assign src_active  = active_reg;
  assign trigger_out = trig_reg;
  assign busy        = (state_reg == ST_STAGE);

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: register vector table, directed corner sequences,
// and random source traffic checked against an event-list reference model.
module tb_trigger_sequencer;
  localparam int N = 4;
  localparam logic [7:0] A_CFG  = 8'h50;
  localparam logic [7:0] A_WIN  = 8'h51;
  localparam logic [7:0] A_STAT = 8'h52;

  logic         clk_usb = 1'b0;
  logic         reset;
  logic [7:0]   reg_address;
  logic [6:0]   reg_bytecnt;
  logic [7:0]   reg_datai;
  logic [7:0]   reg_datao;
  logic         reg_read;
  logic         reg_write;
  logic         arm;
  logic [N-1:0] src_toggle;
  logic [N-1:0] src_active;
  logic         trigger_out;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int trig_cnt = 0;
  int trig_cyc = -1;

  trigger_sequencer #(.pNUM_SRC(N), .pBYTECNT_SIZE(7)) dut (
    .clk_usb(clk_usb), .reset(reset),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai),
    .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write),
    .arm(arm), .src_toggle(src_toggle), .src_active(src_active),
    .trigger_out(trigger_out), .busy(busy)
  );

  always #5 clk_usb = ~clk_usb;

  // cyc equals the number of rising edges seen so far.
  always @(posedge clk_usb) cyc <= cyc + 1;

  always @(posedge clk_usb) begin
    #1;
    if (trigger_out === 1'b1) begin
      trig_cnt = trig_cnt + 1;
      trig_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_usb);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
    reg_address = a; reg_bytecnt = bc; reg_datai = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [6:0] bc, input logic en, output logic [7:0] d);
    reg_address = a; reg_bytecnt = bc; reg_read = en;
    #1;
    d = reg_datao;
    reg_read = 1'b0;
  endtask

  task automatic cfg(input int num, input int win, input bit en, input bit rst);
    wr(A_CFG, 7'd0, 8'(num));
    wr(A_CFG, 7'd1, {6'd0, rst, en});
    wr(A_WIN, 7'd0, 8'(win));
    wr(A_WIN, 7'd1, 8'(win >> 8));
  endtask

  task automatic status(output int code, output int stage, output int tcnt);
    logic [7:0] b0, b1;
    rd(A_STAT, 7'd0, 1'b1, b0);
    rd(A_STAT, 7'd1, 1'b1, b1);
    code = int'(b0[6:4]); stage = int'(b0[3:0]); tcnt = int'(b1);
  endtask

  task automatic toggle(input int i);
    src_toggle[i] = ~src_toggle[i];
  endtask

  // Reference model: works on the list of event times (toggle cycle + 3), not on cycles.
  int m_state, m_stage, m_adv, m_to, m_trig_t, m_n, m_win;
  bit m_rst;

  task automatic model_event(input int src, input int t);
    bit dropped;
    dropped = 1'b0;
    if (m_state == 1 && m_stage > 0 && m_win != 0 && t >= m_adv + m_win &&
        !(t == m_adv + m_win && src == m_stage)) begin
      m_to++;
      dropped = (t == m_adv + m_win);
      if (m_rst) m_stage = 0;
      else       m_state = 3;
    end
    if (!dropped && m_state == 1 && src == m_stage) begin
      if (m_stage == m_n - 1) begin
        m_state  = 2;
        m_trig_t = t;
      end else begin
        m_stage++;
        m_adv = t;
      end
    end
  endtask

  typedef struct {
    bit         wr;
    bit         rd_en;
    logic [7:0] addr;
    logic [6:0] bc;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[17];

  initial begin
    int code, stage, tcnt, base, last_src, src, num, win, rst, t;
    logic [7:0] d;

    vt[0]  = '{0, 1, A_CFG,  7'd0, 8'h00, 8'h00};
    vt[1]  = '{0, 1, A_CFG,  7'd1, 8'h00, 8'h00};
    vt[2]  = '{0, 1, A_WIN,  7'd0, 8'h00, 8'h00};
    vt[3]  = '{0, 1, A_STAT, 7'd0, 8'h00, 8'h00};
    vt[4]  = '{0, 1, A_STAT, 7'd1, 8'h00, 8'h00};
    vt[5]  = '{1, 0, A_CFG,  7'd0, 8'h07, 8'h00};
    vt[6]  = '{1, 0, A_CFG,  7'd1, 8'h03, 8'h00};
    vt[7]  = '{1, 0, A_WIN,  7'd0, 8'h34, 8'h00};
    vt[8]  = '{1, 0, A_WIN,  7'd1, 8'h12, 8'h00};
    vt[9]  = '{0, 1, A_CFG,  7'd0, 8'h00, 8'h07};
    vt[10] = '{0, 1, A_CFG,  7'd1, 8'h00, 8'h03};
    vt[11] = '{0, 1, A_WIN,  7'd0, 8'h00, 8'h34};
    vt[12] = '{0, 1, A_WIN,  7'd1, 8'h00, 8'h12};
    vt[13] = '{0, 1, A_WIN,  7'd2, 8'h00, 8'h00};
    vt[14] = '{0, 1, 8'h00,  7'd0, 8'h00, 8'h00};
    vt[15] = '{0, 0, A_CFG,  7'd0, 8'h00, 8'h00};
    vt[16] = '{0, 1, A_CFG,  7'd2, 8'h00, 8'h00};

    reset = 1'b1; reg_address = 8'd0; reg_bytecnt = 7'd0; reg_datai = 8'd0;
    reg_read = 1'b0; reg_write = 1'b0; arm = 1'b0; src_toggle = '0;
    tick(3);
    reset = 1'b0;
    tick();
    chk("reset_src_active", int'(src_active), 0);
    chk("reset_trigger", int'(trigger_out), 0);
    chk("reset_busy", int'(busy), 0);

    for (int i = 0; i < 17; i++) begin
      if (vt[i].wr) begin
        wr(vt[i].addr, vt[i].bc, vt[i].data);
      end else begin
        rd(vt[i].addr, vt[i].bc, vt[i].rd_en, d);
        chk($sformatf("regvec%0d", i), int'(d), int'(vt[i].exp));
      end
    end
    $display("register vectors applied: %0d", 17);

    // Basic three-stage sequence.
    cfg(3, 0, 1, 0);
    arm = 1'b1; tick();
    chk("basic_busy", int'(busy), 1);
    chk("basic_active0", int'(src_active), 1);
    toggle(0); tick(2);
    chk("basic_latency", int'(src_active), 1);
    tick();
    chk("basic_active1", int'(src_active), 2);
    toggle(1); tick(3);
    chk("basic_active2", int'(src_active), 4);
    toggle(2); tick(2);
    chk("basic_trig_early", int'(trigger_out), 0);
    tick();
    chk("basic_trig", int'(trigger_out), 1);
    chk("basic_active_done", int'(src_active), 0);
    tick();
    chk("basic_trig_single", int'(trigger_out), 0);
    status(code, stage, tcnt);
    chk("basic_done_code", code, 2);
    $display("basic sequence complete");

    // Wrong source is ignored.
    arm = 1'b0; tick();
    status(code, stage, tcnt);
    chk("done_to_idle", code, 0);
    cfg(2, 0, 1, 0);
    arm = 1'b1; tick();
    toggle(1); tick(4);
    status(code, stage, tcnt);
    chk("wrong_src_stage", stage, 0);
    chk("wrong_src_active", int'(src_active), 1);
    toggle(0); tick(3);
    chk("wrong_src_adv", int'(src_active), 2);
    toggle(1); tick(3);
    chk("wrong_src_trig", int'(trigger_out), 1);
    $display("wrong-source sequence complete");

    // Timeout without restart.
    arm = 1'b0; tick();
    cfg(2, 10, 1, 0);
    arm = 1'b1; tick();
    toggle(0); tick(3);
    tick(9);
    status(code, stage, tcnt);
    chk("to_before", code, 1);
    tick();
    status(code, stage, tcnt);
    chk("to_failed", code, 3);
    chk("to_active", int'(src_active), 0);
    chk("to_count", tcnt, 1);
    arm = 1'b0; tick();
    status(code, stage, tcnt);
    chk("failed_to_idle", code, 0);
    $display("timeout without restart complete");

    // Event lands in the timeout cycle.
    arm = 1'b1; tick();
    toggle(0); tick(3);
    tick(7);
    toggle(1); tick(3);
    chk("collide_trig", int'(trigger_out), 1);
    status(code, stage, tcnt);
    chk("collide_code", code, 2);
    chk("collide_tcnt", tcnt, 1);
    $display("event/timeout collision complete");

    // Timeout with restart, saturating counter.
    arm = 1'b0; tick();
    cfg(2, 10, 1, 1);
    arm = 1'b1; tick();
    for (int k = 0; k < 300; k++) begin
      toggle(0); tick(3);
      tick(10);
      if (k == 0) begin
        status(code, stage, tcnt);
        chk("restart_stage", stage, 0);
        chk("restart_active", int'(src_active), 1);
        chk("restart_tcnt", tcnt, 2);
      end
    end
    status(code, stage, tcnt);
    chk("restart_sat", tcnt, 255);
    chk("restart_busy", int'(busy), 1);
    wr(A_STAT, 7'd1, 8'h00);
    status(code, stage, tcnt);
    chk("status_clear", tcnt, 0);
    $display("timeout with restart complete");

    // Shadowed window: a mid-run write does not shorten the current run.
    arm = 1'b0; tick();
    cfg(2, 100, 1, 0);
    arm = 1'b1; tick();
    toggle(0); tick(3);
    wr(A_WIN, 7'd0, 8'd5);
    wr(A_WIN, 7'd1, 8'd0);
    tick(97);
    status(code, stage, tcnt);
    chk("shadow_still_stage", code, 1);
    tick();
    status(code, stage, tcnt);
    chk("shadow_failed", code, 3);
    arm = 1'b0; tick();

    // Abort by arm low at stage 1.
    base = trig_cnt;
    arm = 1'b1; tick();
    toggle(0); tick(3);
    arm = 1'b0; tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_active", int'(src_active), 0);
    status(code, stage, tcnt);
    chk("abort_code", code, 0);
    chk("abort_tcnt", tcnt, 1);
    chk("abort_no_trig", trig_cnt - base, 0);

    // Abort by enable low.
    arm = 1'b1; tick();
    wr(A_CFG, 7'd1, 8'h00);
    tick();
    chk("disable_abort", int'(busy), 0);

    // Reset in the middle of a run.
    wr(A_CFG, 7'd1, 8'h01);
    arm = 1'b0; tick();
    arm = 1'b1; tick();
    chk("pre_reset_busy", int'(busy), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset_mid_busy", int'(busy), 0);
    chk("reset_mid_active", int'(src_active), 0);
    chk("reset_mid_trig", int'(trigger_out), 0);
    rd(A_CFG, 7'd0, 1'b1, d);
    chk("reset_mid_cfg0", int'(d), 0);
    rd(A_CFG, 7'd1, 1'b1, d);
    chk("reset_mid_cfg1", int'(d), 0);
    arm = 1'b0; tick();
    $display("abort and shadowing complete");

    // Randomized runs against the reference model.
    for (int r = 0; r < 40; r++) begin
      arm = 1'b0; tick(2);
      num = $urandom_range(0, 6);
      win = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 12);
      rst = $urandom_range(0, 1);
      cfg(num, win, 1, rst[0]);
      wr(A_STAT, 7'd0, 8'h00);
      m_n = (num == 0) ? 1 : ((num > N) ? N : num);
      m_win = win; m_rst = rst[0];
      m_state = 1; m_stage = 0; m_to = 0; m_trig_t = -1;
      base = trig_cnt;
      arm = 1'b1; tick();
      m_adv = cyc;
      last_src = -1;
      for (int e = 0; e < 12; e++) begin
        tick($urandom_range(1, 6));
        if ($urandom_range(0, 1) == 1) src = (last_src + 1) % N;
        else                           src = $urandom_range(0, N - 1);
        last_src = src;
        t = cyc + 3;
        toggle(src);
        model_event(src, t);
      end
      tick(3 + win + 2);
      model_event(-1, cyc);
      status(code, stage, tcnt);
      chk($sformatf("rand%0d_code", r), code, m_state);
      if (m_state == 1) chk($sformatf("rand%0d_stage", r), stage, m_stage);
      chk($sformatf("rand%0d_tcnt", r), tcnt, (m_to > 255) ? 255 : m_to);
      chk($sformatf("rand%0d_trigs", r), trig_cnt - base, (m_trig_t >= 0) ? 1 : 0);
      if (m_trig_t >= 0) chk($sformatf("rand%0d_trig_cyc", r), trig_cyc, m_trig_t);
      $display("run %0d: stages=%0d window=%0d restart=%0d -> state %0d timeouts %0d",
               r, m_n, win, rst, code, tcnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
